// File: rtl/sbox_word_arbiter.sv
// Round-robin arbiter that time-shares one combinational S-box between two 32-bit word requesters.
// Optional macro SBOX_PIPE_EN registers sbox_out once before capture and adds a DRAIN state.
module sbox_word_arbiter #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_word,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_word,
  output logic        req1_ready,
  output logic [7:0]  sbox_in,
  input  logic [7:0]  sbox_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_word,
  input  logic        rsp_ready
);

`ifdef SBOX_PIPE_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StSub = 2'd1, StDrain = 2'd2, StDone = 2'd3} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StSub = 2'd1, StDone = 2'd3} state_e;
`endif

  state_e      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_last;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_word;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;

  // r_last holds the id granted most recently; a tie goes to the other one.
  assign w_gnt0   = req0_valid & (~req1_valid | r_last);
  assign w_gnt1   = req1_valid & (~req0_valid | ~r_last);
  // Gating with rst_n keeps both readys low while reset is held.
  assign w_idle   = rst_n & (r_state == StIdle);
  assign w_accept = w_idle & (w_gnt0 | w_gnt1);

  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign sbox_in    = (r_state == StSub) ? r_word[{r_cnt, 3'b000} +: 8] : IDLE_BYTE;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_word   = r_rsp_word;

`ifdef SBOX_PIPE_EN
  logic [7:0] r_sbox_q;
  logic [1:0] w_cap_idx;

  assign w_cap_idx = r_cnt - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbox_q <= 8'h00;
    end else begin
      r_sbox_q <= sbox_out;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 2'd0;
      r_word      <= 32'h0;
      r_last      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_word  <= 32'h0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_word   <= w_gnt0 ? req0_word : req1_word;
            r_rsp_id <= w_gnt1;
            r_last   <= w_gnt1;
            r_cnt    <= 2'd0;
            r_state  <= StSub;
          end
        end
        StSub: begin
`ifdef SBOX_PIPE_EN
          // Registered S-box result belongs to the byte presented last cycle.
          if (r_cnt != 2'd0) begin
            r_rsp_word[{w_cap_idx, 3'b000} +: 8] <= r_sbox_q;
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= StDrain;
          end
`else
          r_rsp_word[{r_cnt, 3'b000} +: 8] <= sbox_out;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state     <= StDone;
            r_rsp_valid <= 1'b1;
          end
`endif
        end
`ifdef SBOX_PIPE_EN
        StDrain: begin
          r_rsp_word[31:24] <= r_sbox_q;
          r_state           <= StDone;
          r_rsp_valid       <= 1'b1;
        end
`endif
        StDone: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_word_arbiter.sv
// Directed self-checking bench for sbox_word_arbiter (default build, no S-box pipeline register).
module tb_sbox_word_arbiter;

  localparam logic [7:0] IdleByte = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_word;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_word;
  logic        req1_ready;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_word;
  logic        rsp_ready;

  int n_checks = 0;
  int n_fail   = 0;

  sbox_word_arbiter #(.IDLE_BYTE(IdleByte)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_word  (req0_word),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_word  (req1_word),
    .req1_ready (req1_ready),
    .sbox_in    (sbox_in),
    .sbox_out   (sbox_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_word   (rsp_word),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real AES S-box entries for every byte the stimulus uses.
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    case (b)
      8'h00: sbox_f = 8'h63;
      8'h01: sbox_f = 8'h7c;
      8'h02: sbox_f = 8'h77;
      8'h03: sbox_f = 8'h7b;
      8'h04: sbox_f = 8'hf2;
      8'h05: sbox_f = 8'h6b;
      8'h06: sbox_f = 8'h6f;
      8'h07: sbox_f = 8'hc5;
      8'h0c: sbox_f = 8'hfe;
      8'h0d: sbox_f = 8'hd7;
      8'h0e: sbox_f = 8'hab;
      8'h0f: sbox_f = 8'h76;
      8'h53: sbox_f = 8'hed;
      8'hff: sbox_f = 8'h16;
      default: sbox_f = ~b;
    endcase
  endfunction

  always_comb sbox_out = sbox_f(sbox_in);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept on the next edge, then check four SUB cycles and the DONE cycle.
  task automatic xfer(input string tag, input logic [31:0] w, input logic [31:0] exp_rsp,
                      input logic exp_id, input bit mutate);
    tick();
    if (mutate) begin
      req0_word = 32'hDEADBEEF;
      req1_word = 32'hDEADBEEF;
    end
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_sbox_in"}, {24'h0, sbox_in}, {24'h0, w[8*i +: 8]});
      chk({tag, "_valid_low"}, {31'h0, rsp_valid}, 32'h0);
      chk({tag, "_rdy_low"}, {30'h0, req1_ready, req0_ready}, 32'h0);
      tick();
    end
    chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, "_rsp_word"}, rsp_word, exp_rsp);
    chk({tag, "_rsp_id"}, {31'h0, rsp_id}, {31'h0, exp_id});
    chk({tag, "_idle_byte"}, {24'h0, sbox_in}, {24'h0, IdleByte});
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_word  = 32'h0;
    req1_valid = 1'b0;
    req1_word  = 32'h0;
    rsp_ready  = 1'b0;
    #1;
    // Reset state, with a requester already valid.
    req0_valid = 1'b1;
    req0_word  = 32'hFF530100;
    #1;
    chk("rst_rdy", {30'h0, req1_ready, req0_ready}, 32'h0);
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_word", rsp_word, 32'h0);
    chk("rst_id", {31'h0, rsp_id}, 32'h0);
    chk("rst_sbox_in", {24'h0, sbox_in}, {24'h0, IdleByte});
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("first_rdy", {30'h0, req1_ready, req0_ready}, 32'h1);

    // Single word, request word changed during SUB, then 10-cycle stall.
    xfer("p2", 32'hFF530100, 32'h16ED7C63, 1'b0, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_word  = 32'h00000000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold_word", rsp_word, 32'h16ED7C63);
      chk("hold_rdy", {30'h0, req1_ready, req0_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("consume_valid", {31'h0, rsp_valid}, 32'h0);
    chk("consume_rdy", {30'h0, req1_ready, req0_ready}, 32'h2);
    chk("consume_sbox_in", {24'h0, sbox_in}, {24'h0, IdleByte});

    // Requester 1 alone with an all-zero word.
    xfer("p3", 32'h00000000, 32'h63636363, 1'b1, 1'b0);
    req1_valid = 1'b0;
    tick();
    chk("p3_done_valid", {31'h0, rsp_valid}, 32'h0);

    // Reset pulsed while counter is 2.
    req0_valid = 1'b1;
    req0_word  = 32'h03020100;
    #1;
    chk("p4_rdy", {30'h0, req1_ready, req0_ready}, 32'h1);
    tick();
    tick();
    tick();
    chk("p4_cnt2_byte", {24'h0, sbox_in}, 32'h02);
    rst_n = 1'b0;
    #1;
    chk("p4_rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("p4_rst_word", rsp_word, 32'h0);
    chk("p4_rst_id", {31'h0, rsp_id}, 32'h0);
    chk("p4_rst_sbox_in", {24'h0, sbox_in}, {24'h0, IdleByte});
    chk("p4_rst_rdy", {30'h0, req1_ready, req0_ready}, 32'h0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("p4_no_rsp", {31'h0, rsp_valid}, 32'h0);
    end

    // Simultaneous requests from reset: req0, req1, then req0 again.
    req0_valid = 1'b1;
    req0_word  = 32'h07060504;
    req1_valid = 1'b1;
    req1_word  = 32'h0F0E0D0C;
    rsp_ready  = 1'b1;
    #1;
    chk("tie1_rdy", {30'h0, req1_ready, req0_ready}, 32'h1);
    xfer("tie1", 32'h07060504, 32'hC56F6BF2, 1'b0, 1'b0);
    tick();
    chk("tie2_rdy", {30'h0, req1_ready, req0_ready}, 32'h2);
    xfer("tie2", 32'h0F0E0D0C, 32'h76ABD7FE, 1'b1, 1'b0);
    tick();
    chk("tie3_rdy", {30'h0, req1_ready, req0_ready}, 32'h1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_word_arbiter.md
SBOX_WORD_ARBITER -- requirements
Module: sbox_word_arbiter

Interface
REQ-001 SHALL have parameter: IDLE_BYTE, default 8'h00, value driven on sbox_in when no byte is being substituted.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 (round datapath) has a word.
REQ-005 SHALL have port: req0_word  input  32  word to substitute; byte 0 = bits [7:0].
REQ-006 SHALL have port: req0_ready  output  1  word accepted when valid&ready.
REQ-007 SHALL have ports: req1_valid, req1_word, req1_ready, identical to req0_*, for requester 1 (key expansion SubWord).
REQ-008 SHALL have port: sbox_in  output  8  byte presented to the shared combinational S-box.
REQ-009 SHALL have port: sbox_out  input  8  substituted byte returned by the S-box.
REQ-010 SHALL have port: rsp_valid  output  1  substituted word available.
REQ-011 SHALL have port: rsp_id  output  1  requester that owns rsp_word.
REQ-012 SHALL have port: rsp_word  output  32  substituted word; byte i = S(request byte i).
REQ-013 SHALL have port: rsp_ready  input  1  consumer takes response when rsp_valid&rsp_ready.

Function
REQ-014 SHALL implement FSM states IDLE, SUB, DRAIN (only with SBOX_PIPE_EN), DONE.
REQ-015 SHALL assert reqN_ready only in IDLE and only for the granted requester; at most one ready high per cycle.
REQ-016 SHALL grant round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-017 SHALL, on accept in IDLE, latch word and id, clear 2-bit byte counter, move to SUB.
REQ-018 SHALL in SUB drive sbox_in = latched byte[counter], byte 0 first, one byte per cycle, four cycles.
REQ-019 SHALL capture sbox_out into rsp_word byte[counter] in the same cycle (no macro), increment counter, leave SUB after counter 3.
REQ-020 SHALL drive sbox_in = IDLE_BYTE outside SUB.
REQ-021 SHALL, without macro, assert rsp_valid in the 5th cycle after the accept cycle (accept at t, rsp_valid at t+5).
REQ-022 SHALL hold rsp_valid, rsp_id, rsp_word stable in DONE until rsp_valid&rsp_ready, then return to IDLE.
REQ-023 SHALL not accept a new request in the cycle the response is consumed; earliest next accept is the following cycle (one outstanding word).
REQ-024 SHALL ignore reqN_word/valid changes after accept; latched copy is used.
REQ-025 SHALL keep rsp_word byte lanes unwritten in SUB unchanged from previous response until written.

Reset
REQ-026 SHALL, on rst_n low, immediately force: state IDLE, counter 0, rsp_valid 0, rsp_id 0, rsp_word 0, req0_ready 0, req1_ready 0, sbox_in IDLE_BYTE, round-robin pointer so that requester 0 wins first tie.
REQ-027 SHALL abandon any in-flight word on reset mid-operation; no response emitted for it.
REQ-028 SHALL allow first accept in the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL support macro SBOX_PIPE_EN: when defined, sbox_out is registered once before capture, byte i captured one cycle after it is presented, DRAIN state captures byte 3, rsp_valid at t+6.
REQ-030 SHALL, when SBOX_PIPE_EN undefined, contain no S-box output register and no DRAIN state; latency per REQ-021.

Verification
REQ-031 SHALL test: reset, req0_word=32'hFF530100 alone -> rsp_word=32'h16ED7C63, rsp_id=0, rsp_valid at t+5 (t+6 with SBOX_PIPE_EN).
REQ-032 SHALL test: req0 and req1 valid together from reset, rsp_ready=1 -> grants req0 first, then req1; next tie grants req0 again.
REQ-033 SHALL test: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_word stable, both reqN_ready low throughout.
REQ-034 SHALL test: rst_n pulsed low during SUB counter=2 -> outputs at reset values immediately, no rsp_valid for that word.
REQ-035 SHALL test: req1_word=32'h00000000 -> rsp_word=32'h63636363; sbox_in=IDLE_BYTE in all non-SUB cycles.
REQ-036 SHALL test: reqN_word changed during SUB -> response reflects word latched at accept.
